// File: rtl/multiword_addsub_sequencer_if.sv
// Operand/result bundle for the multiword add/subtract sequencer.
// The master modport is the requester side; the slave modport is the sequencer.
interface multiword_addsub_sequencer_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = N * WORDS;

    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/multiword_addsub_sequencer.sv
// W = N*WORDS bit add/subtract built from one N-bit adder-subtractor slice,
// processed LS slice first with carry/borrow chained through r_chain.
module multiword_addsub_sequencer #(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    multiword_addsub_sequencer_if.slave   bus
);
    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [W-1:0]    r_a, w_a_d;
    logic [W-1:0]    r_b, w_b_d;
    logic            r_op, w_op_d;
    logic [IdxW-1:0] r_idx, w_idx_d;
    logic            r_chain, w_chain_d;
    logic [W-1:0]    r_result, w_result_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;
    logic            r_carry, w_carry_d;
    logic            r_ovf, w_ovf_d;
    logic            r_zero, w_zero_d;

    int unsigned     w_base;
    logic [N-1:0]    w_a_sl, w_b_sl, w_slice;
    logic [N:0]      w_add_ext, w_sub_ext;
    logic            w_cin, w_bin, w_cout;
    logic [W-1:0]    w_res_upd;

    // Shared N-bit adder-subtractor slice: Sum/Cout and Sub/Bout.
    always_comb begin
        w_base    = N * 32'(r_idx);
        w_a_sl    = r_a[w_base +: N];
        w_b_sl    = r_b[w_base +: N];
        w_cin     = r_op ? 1'b0 : r_chain;
        w_bin     = r_op ? r_chain : 1'b0;
        w_add_ext = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{N{1'b0}}, w_cin};
        w_sub_ext = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{N{1'b0}}, w_bin};
        w_slice   = r_op ? w_sub_ext[N-1:0] : w_add_ext[N-1:0];
        w_cout    = r_op ? w_sub_ext[N] : w_add_ext[N];
        w_res_upd = r_result;
        w_res_upd[w_base +: N] = w_slice;
    end

    always_comb begin
        w_state_d  = r_state;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_op_d     = r_op;
        w_idx_d    = r_idx;
        w_chain_d  = r_chain;
        w_result_d = r_result;
        w_busy_d   = r_busy;
        w_done_d   = 1'b0;
        w_carry_d  = r_carry;
        w_ovf_d    = r_ovf;
        w_zero_d   = r_zero;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_a_d     = bus.a_in;
                    w_b_d     = bus.b_in;
                    w_op_d    = bus.op;
                    w_idx_d   = '0;
                    w_chain_d = 1'b0;
                    w_busy_d  = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_result_d = w_res_upd;
                w_chain_d  = w_cout;
                w_idx_d    = r_idx + 1'b1;
                if (r_idx == LastIdx) begin
                    w_idx_d   = '0;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_carry_d = w_cout;
                    // Signed overflow judged on the full result including this last slice.
                    w_ovf_d   = r_op ? ((r_a[W-1] != r_b[W-1]) && (w_res_upd[W-1] != r_a[W-1]))
                                     : ((r_a[W-1] == r_b[W-1]) && (w_res_upd[W-1] != r_a[W-1]));
                    w_zero_d  = (w_res_upd == '0);
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_chain  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_op     <= w_op_d;
            r_idx    <= w_idx_d;
            r_chain  <= w_chain_d;
            r_result <= w_result_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_carry  <= w_carry_d;
            r_ovf    <= w_ovf_d;
            r_zero   <= w_zero_d;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry;
    assign bus.overflow  = r_ovf;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Directed bench for multiword_addsub_sequencer (N=4, WORDS=4, 16-bit operands).
module tb_multiword_addsub_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    multiword_addsub_sequencer_if #(.N(4), .WORDS(4)) bus ();

    multiword_addsub_sequencer #(.N(4), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge E0, then check busy/done each cycle through the return to IDLE.
    task automatic run_op(input string tag, input logic op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_c, input logic exp_ovf, input logic exp_z);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        tick();
        bus.start = 1'b0;
        chk({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk({tag, " busy"}, 32'(bus.busy), 32'(i < 4));
            chk({tag, " done"}, 32'(bus.done), 32'(i == 4));
        end
        chk({tag, " result"},   32'(bus.result),    32'(exp_res));
        chk({tag, " carry"},    32'(bus.carry_out), 32'(exp_c));
        chk({tag, " overflow"}, 32'(bus.overflow),  32'(exp_ovf));
        chk({tag, " zero"},     32'(bus.zero),      32'(exp_z));
        tick();
        chk({tag, " done_clr"}, 32'(bus.done), 32'd0);
        chk({tag, " hold"},     32'(bus.result), 32'(exp_res));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        tick();
        tick();
        chk("rst busy",   32'(bus.busy),      32'd0);
        chk("rst done",   32'(bus.done),      32'd0);
        chk("rst result", 32'(bus.result),    32'd0);
        chk("rst flags",  32'({bus.carry_out, bus.overflow, bus.zero}), 32'd0);
        rst = 1'b1;
        tick();

        run_op("add1234", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("addFFFF", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add7FFF", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub4_6",  1'b1, 16'h0004, 16'h0006, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_op("sub10_1", 1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Inputs disturbed during RUN and a start held through DONE.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 16'h0001;
        bus.b_in  = 16'h0001;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a_in  = 16'hFFFF;
        bus.b_in  = 16'h1234;
        tick();
        bus.b_in  = 16'h5555;
        tick();
        bus.start = 1'b0;
        tick();
        chk("ign done",   32'(bus.done),   32'd1);
        chk("ign result", 32'(bus.result), 32'h0002);
        chk("ign carry",  32'(bus.carry_out), 32'd0);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 16'h0003;
        bus.b_in  = 16'h0004;
        tick();
        chk("done-start busy", 32'(bus.busy), 32'd0);
        chk("done-start done", 32'(bus.done), 32'd0);
        tick();
        bus.start = 1'b0;
        chk("next accept busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("next done",   32'(bus.done),   32'd1);
        chk("next result", 32'(bus.result), 32'h0007);
        tick();

        run_op("sub8000", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);

        // Reset asserted on the second RUN edge abandons the operation.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a_in  = 16'h00FF;
        bus.b_in  = 16'h0001;
        tick();
        bus.start = 1'b0;
        tick();
        chk("pre-rst result", 32'(bus.result), 32'h7FF0);
        rst = 1'b0;
        tick();
        chk("midrst busy",   32'(bus.busy),   32'd0);
        chk("midrst done",   32'(bus.done),   32'd0);
        chk("midrst result", 32'(bus.result), 32'd0);
        chk("midrst flags",  32'({bus.carry_out, bus.overflow, bus.zero}), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no done after rst", 32'(bus.done), 32'd0);
        end

        run_op("add3_5", 1'b0, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
